// File: rtl/cam_search_arb_pkg.sv
// Shared types and default widths for the tag CAM blocks (search arbiter, cam_cntrl, cam).
package cam_pkg;

    localparam int CAM_DATA_W  = 32;
    localparam int CAM_ADDR_W  = 5;
    localparam int CAM_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // "end" is a reserved word, hence the _idx suffixes on the window fields.
    typedef struct packed {
        logic [CAM_DATA_W-1:0] data;
        logic [CAM_ADDR_W-1:0] start_idx;
        logic [CAM_ADDR_W-1:0] end_idx;
    } cam_search_req_t;

    function automatic int rr_next(input int win, input int n);
        return (win + 1) % n;
    endfunction

endpackage

// File: rtl/cam_search_arb_rr_arbiter.sv
// Combinational round-robin pick: first active request at or above the pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic w_found;
    int   w_slot;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_slot  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_slot = (int'(ptr_i) + i) % NUM_REQ;
            if (!w_found && req_i[w_slot]) begin
                w_found       = 1'b1;
                gnt_o[w_slot] = 1'b1;
                idx_o         = IDX_W'(w_slot);
            end
        end
    end

endmodule

// File: rtl/cam_search_arb.sv
// Round-robin arbiter for the tag CAM search port; one search in flight at a time.
// Optional CAM_SEARCH_ARB_TIMEOUT_EN bounds the wait for cam_done_i and flags rsp_err_o.
module cam_search_arb
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH = CAM_DATA_W,
    parameter int ADDR_WIDTH = CAM_ADDR_W,
    parameter int NUM_REQ    = CAM_NUM_REQ,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_start_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_end_i,
    input  logic                          wr_en_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic                          rsp_hit_o,
    output logic [ADDR_WIDTH-1:0]         rsp_index_o,
    output logic                          rsp_err_o,
    output logic                          cam_search_o,
    output logic [DATA_WIDTH-1:0]         cam_search_data_o,
    output logic [ADDR_WIDTH-1:0]         cam_start_o,
    output logic [ADDR_WIDTH-1:0]         cam_end_o,
    input  logic                          cam_done_i,
    input  logic                          cam_hit_i,
    input  logic [ADDR_WIDTH-1:0]         cam_index_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t r_state;
    arb_state_t w_next;

    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_win;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [DATA_WIDTH-1:0] r_key;
    logic [ADDR_WIDTH-1:0] r_start;
    logic [ADDR_WIDTH-1:0] r_end;
    logic                  r_hit;
    logic [ADDR_WIDTH-1:0] r_index;
    logic                  r_err;

    logic [NUM_REQ-1:0]    w_pick;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_issue;
    logic                  w_done;
    logic                  w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i (req_i),
        .ptr_i (r_ptr),
        .gnt_o (w_pick),
        .idx_o (w_pick_idx)
    );

    // A write on the CAM only blocks the decision to start a new search.
    assign w_issue = (r_state == IDLE) && (|req_i) && !wr_en_i;
    assign w_done  = (r_state == WAIT) && cam_done_i;

`ifdef CAM_SEARCH_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst || (r_state != WAIT)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_timeout = (r_state == WAIT) && !cam_done_i &&
                       (r_to_cnt == TO_W'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (w_done || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_key   <= '0;
            r_start <= '0;
            r_end   <= '0;
            r_hit   <= 1'b0;
            r_index <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_gnt   <= w_pick;
                r_win   <= w_pick_idx;
                r_key   <= req_data_i[int'(w_pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                r_start <= req_start_i[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                r_end   <= req_end_i[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            end
            // The CAM may leave a stale index on a miss; only a hit's index is kept.
            if (w_done) begin
                r_hit   <= cam_hit_i;
                r_index <= cam_hit_i ? cam_index_i : '0;
                r_err   <= 1'b0;
            end else if (w_timeout) begin
                r_hit   <= 1'b0;
                r_index <= '0;
                r_err   <= 1'b1;
            end
            if (r_state == RESP) begin
                r_gnt <= '0;
                r_ptr <= IDX_W'(rr_next(int'(r_win), NUM_REQ));
            end
        end
    end

    always_comb begin
        gnt_o             = r_gnt;
        cam_search_o      = (r_state == ISSUE);
        cam_search_data_o = r_key;
        cam_start_o       = r_start;
        cam_end_o         = r_end;
        rsp_valid_o       = '0;
        rsp_hit_o         = 1'b0;
        rsp_index_o       = '0;
        rsp_err_o         = 1'b0;
        if (r_state == RESP) begin
            rsp_valid_o = r_gnt;
            rsp_hit_o   = r_hit;
            rsp_index_o = r_index;
`ifdef CAM_SEARCH_ARB_TIMEOUT_EN
            rsp_err_o   = r_err;
`endif
        end
    end

`ifndef CAM_SEARCH_ARB_TIMEOUT_EN
    logic w_unused_err;
    assign w_unused_err = r_err;
`endif

endmodule
